// File: rtl/sram_pkg.sv
// Shared helpers for the parametrised 1W1R SRAM: address sizing, write-lane
// merging and configuration legality predicates.
package sram_pkg;

  // Widest word the generic lane-merge helper accepts.
  localparam int SRAM_MAX_W = 1024;

  // Number of address bits needed to index 'value' words.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Replace every lane of old_word whose enable bit is set with the matching
  // lane of new_word; lane k covers bits [k*lane_w +: lane_w].
  function automatic logic [SRAM_MAX_W-1:0] lane_merge(
    input logic [SRAM_MAX_W-1:0] old_word,
    input logic [SRAM_MAX_W-1:0] new_word,
    input logic [SRAM_MAX_W-1:0] lane_en,
    input int                    lane_w
  );
    logic [SRAM_MAX_W-1:0] r;
    r = old_word;
    for (int b = 0; b < SRAM_MAX_W; b++) begin
      if (lane_en[b / lane_w]) r[b] = new_word[b];
    end
    return r;
  endfunction

  // Only single- and double-cycle read latencies exist.
  function automatic bit read_lat_ok(input int lat);
    return (lat == 1) || (lat == 2);
  endfunction

  // The word must split into whole lanes and fit the merge helper.
  function automatic bit lane_split_ok(input int data_w, input int lane_w);
    return (lane_w > 0) && (data_w > 0) && (data_w % lane_w == 0) &&
           (data_w <= SRAM_MAX_W);
  endfunction

endpackage

// File: rtl/sram_rd_pipe.sv
// Read-result delay line: LAT stages carrying valid, data and status flags.
// The final stage holds its data between completions and only pulses its
// valid and flags; async active-low reset empties every stage.
module sram_rd_pipe
  import sram_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int LAT        = 1,
  parameter int FLAG_W     = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [FLAG_W-1:0]     in_flags,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [FLAG_W-1:0]     out_flags
);

  logic [LAT-1:0]                 vld_q;
  logic [LAT-1:0]                 vld_d;
  logic [LAT-1:0][DATA_WIDTH-1:0] data_q;
  logic [LAT-1:0][DATA_WIDTH-1:0] data_d;
  logic [LAT-1:0][FLAG_W-1:0]     flag_q;
  logic [LAT-1:0][FLAG_W-1:0]     flag_d;

  // Each stage is fed by the previous one; stage 0 takes the new read.
  always_comb begin
    vld_d  = '0;
    data_d = '0;
    flag_d = '0;
    vld_d[0]  = in_valid;
    data_d[0] = in_data;
    flag_d[0] = in_flags;
    for (int i = 1; i < LAT; i++) begin
      vld_d[i]  = vld_q[i-1];
      data_d[i] = data_q[i-1];
      flag_d[i] = flag_q[i-1];
    end
  end

  // Shift every cycle; the output stage keeps its data until a read completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= '0;
      data_q <= '0;
      flag_q <= '0;
    end else begin
      for (int i = 0; i < LAT; i++) begin
        vld_q[i] <= vld_d[i];
        if (i == LAT - 1) begin
          if (vld_d[i]) data_q[i] <= data_d[i];
          flag_q[i] <= vld_d[i] ? flag_d[i] : '0;
        end else begin
          data_q[i] <= data_d[i];
          flag_q[i] <= flag_d[i];
        end
      end
    end
  end

  assign out_valid = vld_q[LAT-1];
  assign out_data  = data_q[LAT-1];
  assign out_flags = flag_q[LAT-1];

endmodule

// File: rtl/sram_1w1r_param_pipe.sv
// Parametrised single-clock 1W1R SRAM behavioural macro with lane write
// masks, 1- or 2-cycle read latency, defined same-address collision policy
// and range-error reporting.
// Optional build macro SRAM_UNINIT_CHK_EN adds per-word written flags and
// the uninit1 output; without it dout1 returns raw array contents.
module sram_1w1r_param_pipe
  import sram_pkg::*;
#(
  parameter int DATA_WIDTH  = 64,
  parameter int DEPTH       = 40,
  parameter int ADDR_WIDTH  = 6,
  parameter int WMASK_WIDTH = 32,
  parameter int NUM_WMASKS  = DATA_WIDTH / WMASK_WIDTH,
  parameter int READ_LAT    = 1,
  parameter int COLLIDE_NEW = 1
) (
  input  logic                  clk0,
  input  logic                  rstb0,
  input  logic                  csb0,
  input  logic [NUM_WMASKS-1:0] wmask0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] din0,
  input  logic                  csb1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  output logic [DATA_WIDTH-1:0] dout1,
  output logic                  dvalid1,
  output logic                  err1,
  output logic                  werr0
`ifdef SRAM_UNINIT_CHK_EN
  ,
  output logic                  uninit1
`endif
);

  localparam bit CFG_OK = read_lat_ok(READ_LAT) &&
                          lane_split_ok(DATA_WIDTH, WMASK_WIDTH) &&
                          (NUM_WMASKS * WMASK_WIDTH == DATA_WIDTH) &&
                          (DEPTH > 0) && (clog2(DEPTH) <= ADDR_WIDTH);

  generate
    if (!CFG_OK) begin : g_bad_cfg
      $error("sram_1w1r_param_pipe: illegal parameter combination");
    end
  endgenerate

`ifdef SRAM_UNINIT_CHK_EN
  localparam int FLAG_W = 2;
`else
  localparam int FLAG_W = 1;
`endif

  localparam logic [ADDR_WIDTH:0] DEPTH_LIM = DEPTH[ADDR_WIDTH:0];

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  wr_in_range;
  logic                  rd_in_range;
  logic                  wr_en;
  logic                  collide;
  logic [DATA_WIDTH-1:0] rd_old;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] pipe_in_data;
  logic [FLAG_W-1:0]     pipe_in_flags;
  logic [FLAG_W-1:0]     pipe_out_flags;

  assign wr_in_range = ({1'b0, addr0} < DEPTH_LIM);
  assign rd_in_range = ({1'b0, addr1} < DEPTH_LIM);
  assign wr_en       = !csb0 && wr_in_range;
  assign collide     = wr_en && !csb1 && (addr0 == addr1);

  // Read word as seen at the issuing edge, including same-address bypass.
  always_comb begin
    rd_old  = '0;
    rd_word = '0;
    if (rd_in_range) rd_old = mem[addr1];
    rd_word = rd_old;
    if ((COLLIDE_NEW != 0) && collide) begin
      rd_word = DATA_WIDTH'(lane_merge(SRAM_MAX_W'(rd_old), SRAM_MAX_W'(din0),
                                       SRAM_MAX_W'(wmask0), WMASK_WIDTH));
    end
  end

  // Array contents are deliberately left alone by reset; it only blocks writes.
  always_ff @(posedge clk0 or negedge rstb0) begin
    if (!rstb0) begin
    end else if (wr_en) begin
      mem[addr0] <= DATA_WIDTH'(lane_merge(SRAM_MAX_W'(mem[addr0]), SRAM_MAX_W'(din0),
                                           SRAM_MAX_W'(wmask0), WMASK_WIDTH));
    end
  end

  // Flag a rejected out-of-range write for exactly one cycle.
  always_ff @(posedge clk0 or negedge rstb0) begin
    if (!rstb0) werr0 <= 1'b0;
    else        werr0 <= !csb0 && !wr_in_range;
  end

`ifdef SRAM_UNINIT_CHK_EN
  logic [DEPTH-1:0] written_q;
  logic             rd_uninit;

  assign rd_uninit = rd_in_range && !written_q[addr1];

  // Remember which words have had at least one lane written since reset.
  always_ff @(posedge clk0 or negedge rstb0) begin
    if (!rstb0)                     written_q <= '0;
    else if (wr_en && (|wmask0))    written_q[addr0] <= 1'b1;
  end

  assign pipe_in_flags = {rd_uninit, !rd_in_range};
  assign pipe_in_data  = (rd_in_range && !rd_uninit) ? rd_word : '0;
  assign uninit1       = pipe_out_flags[1];
`else
  assign pipe_in_flags = !rd_in_range;
  assign pipe_in_data  = rd_word;
`endif

  assign err1 = pipe_out_flags[0];

  sram_rd_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .LAT        (READ_LAT),
    .FLAG_W     (FLAG_W)
  ) u_rd_pipe (
    .clk       (clk0),
    .rst_n     (rstb0),
    .in_valid  (!csb1),
    .in_data   (pipe_in_data),
    .in_flags  (pipe_in_flags),
    .out_valid (dvalid1),
    .out_data  (dout1),
    .out_flags (pipe_out_flags)
  );

endmodule

// File: tb/tb_sram_1w1r_param_pipe.sv
// Bench for sram_1w1r_param_pipe: two instances share one stimulus stream,
// A with READ_LAT=1 / COLLIDE_NEW=1 and B with READ_LAT=2 / COLLIDE_NEW=0.
// Honours SRAM_UNINIT_CHK_EN when the design is built with it.
module tb_sram_1w1r_param_pipe;

  localparam int DW    = 64;
  localparam int DEPTH = 40;
  localparam int AW    = 6;
  localparam int MW    = 32;
  localparam int NM    = 2;

  logic          clk0 = 1'b0;
  logic          rstb0;
  logic          csb0, csb1;
  logic [NM-1:0] wmask0;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] din0;

  logic [DW-1:0] dout_a, dout_b;
  logic          dvalid_a, dvalid_b, err_a, err_b, werr_a, werr_b;
`ifdef SRAM_UNINIT_CHK_EN
  logic          uninit_a, uninit_b;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk0 = ~clk0;

  sram_1w1r_param_pipe #(.READ_LAT(1), .COLLIDE_NEW(1)) dut_a (
    .clk0(clk0), .rstb0(rstb0), .csb0(csb0), .wmask0(wmask0), .addr0(addr0),
    .din0(din0), .csb1(csb1), .addr1(addr1), .dout1(dout_a), .dvalid1(dvalid_a),
    .err1(err_a), .werr0(werr_a)
`ifdef SRAM_UNINIT_CHK_EN
    , .uninit1(uninit_a)
`endif
  );

  sram_1w1r_param_pipe #(.READ_LAT(2), .COLLIDE_NEW(0)) dut_b (
    .clk0(clk0), .rstb0(rstb0), .csb0(csb0), .wmask0(wmask0), .addr0(addr0),
    .din0(din0), .csb1(csb1), .addr1(addr1), .dout1(dout_b), .dvalid1(dvalid_b),
    .err1(err_b), .werr0(werr_b)
`ifdef SRAM_UNINIT_CHK_EN
    , .uninit1(uninit_b)
`endif
  );

  // Reference model: word array, written flags and per-instance result queues
  typedef struct {
    int          due;
    logic [DW-1:0] data;
    logic        err;
    logic        uninit;
  } rd_t;

  logic [DW-1:0] model_mem [DEPTH];
  bit            model_written [DEPTH];
  rd_t           q_a[$];
  rd_t           q_b[$];
  int            cycle = 0;
  logic [DW-1:0] last_a = '0;
  logic [DW-1:0] last_b = '0;
  logic          exp_werr = 1'b0;

  task automatic checkOutput(input string name, input logic [DW-1:0] got,
                             input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic rd_t read_item(input bit new_policy, input int due);
    rd_t it;
    it.due = due; it.err = 1'b0; it.uninit = 1'b0; it.data = '0;
    if (int'(addr1) >= DEPTH) it.err = 1'b1;
`ifdef SRAM_UNINIT_CHK_EN
    else if (!model_written[addr1]) it.uninit = 1'b1;
`endif
    else begin
      it.data = model_mem[addr1];
      if (new_policy && !csb0 && addr0 == addr1) begin
        for (int l = 0; l < NM; l++)
          if (wmask0[l]) it.data[l*MW +: MW] = din0[l*MW +: MW];
      end
    end
    return it;
  endfunction

  // Model advances on each clock edge; reset empties everything in flight
  always @(posedge clk0 or negedge rstb0) begin
    if (!rstb0) begin
      q_a.delete(); q_b.delete();
      last_a = '0; last_b = '0; exp_werr = 1'b0;
      for (int i = 0; i < DEPTH; i++) model_written[i] = 1'b0;
    end else begin
      cycle++;
      exp_werr = !csb0 && (int'(addr0) >= DEPTH);
      if (!csb1) begin
        q_a.push_back(read_item(1'b1, cycle));
        q_b.push_back(read_item(1'b0, cycle + 1));
      end
      if (!csb0 && int'(addr0) < DEPTH) begin
        for (int l = 0; l < NM; l++)
          if (wmask0[l]) model_mem[addr0][l*MW +: MW] = din0[l*MW +: MW];
        if (|wmask0) model_written[addr0] = 1'b1;
      end
    end
  end

  // Compare both instances against the model on every falling edge
  always @(negedge clk0) begin
    rd_t h;
    logic ev;
    h = '{due: 0, data: '0, err: 1'b0, uninit: 1'b0};
    ev = (q_a.size() > 0) && (q_a[0].due == cycle);
    if (ev) begin h = q_a.pop_front(); last_a = h.data; end
    checkOutput("dvalid_a", dvalid_a, ev);
    checkOutput("dout_a", dout_a, last_a);
    checkOutput("err_a", err_a, ev & h.err);
`ifdef SRAM_UNINIT_CHK_EN
    checkOutput("uninit_a", uninit_a, ev & h.uninit);
`endif
    checkOutput("werr_a", werr_a, exp_werr);

    h = '{due: 0, data: '0, err: 1'b0, uninit: 1'b0};
    ev = (q_b.size() > 0) && (q_b[0].due == cycle);
    if (ev) begin h = q_b.pop_front(); last_b = h.data; end
    checkOutput("dvalid_b", dvalid_b, ev);
    checkOutput("dout_b", dout_b, last_b);
    checkOutput("err_b", err_b, ev & h.err);
`ifdef SRAM_UNINIT_CHK_EN
    checkOutput("uninit_b", uninit_b, ev & h.uninit);
`endif
    checkOutput("werr_b", werr_b, exp_werr);
  end

  task automatic applyStimulus(input logic wr, input logic [AW-1:0] wa,
                               input logic [DW-1:0] wd, input logic [NM-1:0] wm,
                               input logic rd, input logic [AW-1:0] ra);
    @(negedge clk0);
    csb0 = ~wr; addr0 = wa; din0 = wd; wmask0 = wm;
    csb1 = ~rd; addr1 = ra;
  endtask

  task automatic idle();
    applyStimulus(1'b0, '0, '0, '0, 1'b0, '0);
  endtask

  task automatic settle();
    @(posedge clk0);
    #1;
  endtask

  initial begin
    logic [DW-1:0] lit [3];
    rstb0 = 1'b0; csb0 = 1'b1; csb1 = 1'b1; wmask0 = '0;
    addr0 = '0; addr1 = '0; din0 = '0;
    settle();
    settle();
    checkOutput("rst_dout_a", dout_a, 64'h0);
    checkOutput("rst_dvalid_a", dvalid_a, 1'b0);
    checkOutput("rst_err_a", err_a, 1'b0);
    checkOutput("rst_werr_a", werr_a, 1'b0);
    checkOutput("rst_dout_b", dout_b, 64'h0);
    @(negedge clk0);
    rstb0 = 1'b1;

`ifdef SRAM_UNINIT_CHK_EN
    applyStimulus(1'b0, '0, '0, '0, 1'b1, 6'd3);
    settle();
    checkOutput("uninit_first_flag", uninit_a, 1'b1);
    checkOutput("uninit_first_dout", dout_a, 64'h0);
    idle();
`endif

    for (int i = 0; i < DEPTH; i++)
      applyStimulus(1'b1, AW'(i), {32'hC0DE_0000 | i, 32'h5A5A_0000 | i}, 2'b11,
                    i > 0, AW'(i - 1));
    applyStimulus(1'b0, '0, '0, '0, 1'b1, 6'd3);
    settle();
    checkOutput("fill_read3", dout_a, 64'hC0DE_0003_5A5A_0003);
`ifdef SRAM_UNINIT_CHK_EN
    checkOutput("written_flag3", uninit_a, 1'b0);
`endif

    applyStimulus(1'b1, 6'd5, 64'hAAAA_BBBB_CCCC_DDDD, 2'b11, 1'b0, '0);
    applyStimulus(1'b1, 6'd5, 64'h1111_2222_3333_4444, 2'b01, 1'b0, '0);
    applyStimulus(1'b0, '0, '0, '0, 1'b1, 6'd5);
    settle();
    checkOutput("mask_dout_a", dout_a, 64'hAAAA_BBBB_3333_4444);
    checkOutput("mask_dvalid_a", dvalid_a, 1'b1);
    idle();
    settle();
    checkOutput("mask_dout_b", dout_b, 64'hAAAA_BBBB_3333_4444);
    checkOutput("mask_dvalid_b", dvalid_b, 1'b1);

    lit[0] = 64'hC0DE_0000_5A5A_0000;
    lit[1] = 64'hC0DE_0001_5A5A_0001;
    lit[2] = 64'hC0DE_0002_5A5A_0002;
    applyStimulus(1'b0, '0, '0, '0, 1'b1, 6'd0);
    settle();
    checkOutput("lat2_early", dvalid_b, 1'b0);
    for (int k = 0; k < 3; k++) begin
      if (k < 2) applyStimulus(1'b0, '0, '0, '0, 1'b1, AW'(k + 1));
      else       idle();
      settle();
      checkOutput("lat2_valid", dvalid_b, 1'b1);
      checkOutput("lat2_data", dout_b, lit[k]);
    end
    idle();
    settle();
    checkOutput("lat2_done", dvalid_b, 1'b0);

    applyStimulus(1'b1, 6'd7, 64'h0, 2'b11, 1'b0, '0);
    applyStimulus(1'b1, 6'd7, 64'hFFFF_FFFF_0000_0001, 2'b01, 1'b1, 6'd7);
    settle();
    checkOutput("collide_new", dout_a, 64'h0000_0000_0000_0001);
    idle();
    settle();
    checkOutput("collide_old", dout_b, 64'h0);
    applyStimulus(1'b0, '0, '0, '0, 1'b1, 6'd7);
    settle();
    checkOutput("collide_after_a", dout_a, 64'h1);
    idle();
    settle();
    checkOutput("collide_after_b", dout_b, 64'h1);

    applyStimulus(1'b1, 6'd8, 64'hFFFF_FFFF_FFFF_FFFF, 2'b00, 1'b0, '0);
    applyStimulus(1'b0, '0, '0, '0, 1'b1, 6'd8);
    settle();
    checkOutput("mask0_noop", dout_a, 64'hC0DE_0008_5A5A_0008);

    applyStimulus(1'b1, 6'd45, 64'h0000_0000_0000_0BAD, 2'b11, 1'b0, '0);
    settle();
    checkOutput("werr_set", werr_a, 1'b1);
    idle();
    settle();
    checkOutput("werr_clear", werr_a, 1'b0);
    applyStimulus(1'b0, '0, '0, '0, 1'b1, 6'd45);
    settle();
    checkOutput("oor_dout", dout_a, 64'h0);
    checkOutput("oor_err", err_a, 1'b1);
    applyStimulus(1'b0, '0, '0, '0, 1'b1, 6'd5);
    settle();
    checkOutput("no_alias5", dout_a, 64'hAAAA_BBBB_3333_4444);
    applyStimulus(1'b0, '0, '0, '0, 1'b1, 6'd45);
    settle();
    checkOutput("oor_again", dout_a, 64'h0);
    idle();

    applyStimulus(1'b0, '0, '0, '0, 1'b1, 6'd1);
    @(posedge clk0);
    #2;
    rstb0 = 1'b0; csb0 = 1'b1; csb1 = 1'b1;
    #1;
    checkOutput("midrst_dout_b", dout_b, 64'h0);
    checkOutput("midrst_dvalid_b", dvalid_b, 1'b0);
    checkOutput("midrst_dout_a", dout_a, 64'h0);
    applyStimulus(1'b1, 6'd9, 64'hDEAD_BEEF_DEAD_BEEF, 2'b11, 1'b1, 6'd9);
    applyStimulus(1'b1, 6'd9, 64'hDEAD_BEEF_DEAD_BEEF, 2'b11, 1'b1, 6'd9);
    @(negedge clk0);
    rstb0 = 1'b1; csb0 = 1'b1; csb1 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      settle();
      checkOutput("post_rst_quiet", dvalid_b, 1'b0);
    end
    applyStimulus(1'b0, '0, '0, '0, 1'b1, 6'd9);
    settle();
`ifdef SRAM_UNINIT_CHK_EN
    checkOutput("rst_drop_write", dout_a, 64'h0);
`else
    checkOutput("rst_drop_write", dout_a, 64'hC0DE_0009_5A5A_0009);
`endif
    idle();
    repeat (4) settle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
